// File: rtl/cavlc_bit_window_if.sv
// Slice-data word handshake into the CAVLC bit window.
// The feeder holds InWord/InValid until it sees InReady high at a clock edge.
interface cavlc_bit_window_if #(
    parameter int unsigned WORD_W = 32
);
    logic [WORD_W-1:0] InWord;
    logic              InValid;
    logic              InReady;

    modport master (
        output InWord,
        output InValid,
        input  InReady
    );

    modport slave (
        input  InWord,
        input  InValid,
        output InReady
    );
endinterface

// File: rtl/cavlc_bit_window.sv
// MSB-first bit buffer feeding the CAVLC decoders with a left-aligned look-ahead window.
// One word load and one shift of up to WIN_W bits can both happen in a single cycle.
module cavlc_bit_window #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned BUF_W  = 64,
    parameter int unsigned WIN_W  = 16
) (
    input  logic                 Clk,
    input  logic                 nReset,
    input  logic                 Flush,
    cavlc_bit_window_if.slave    in_if,
    input  logic                 ShiftEn,
    input  logic [4:0]           NumShift,
    output logic [WIN_W-1:0]     BitstreamShifted,
    output logic                 WindowValid,
    output logic [6:0]           BitCount,
    output logic [31:0]          BitPos,
    output logic                 Error
);
    localparam int unsigned CNT_W = 7;
    localparam int unsigned SHF_W = 5;
    localparam int unsigned POS_W = 32;
    localparam int unsigned PAD_W = BUF_W - WORD_W;

    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             err_q, err_d;

    logic             shift_legal;
    logic [CNT_W-1:0] shift_amt;
    logic [CNT_W-1:0] remain;
    logic             load;
    logic [BUF_W-1:0] word_ext;
    logic             in_ready;

    // Space for a whole word must exist; a flushing cycle never accepts.
    assign in_ready = (count_q <= CNT_W'(PAD_W)) && !Flush;

    // Next-state: shift out consumed bits, then append the new word right behind the remainder.
    always_comb begin
        shift_legal = 1'b0;
        shift_amt   = '0;
        remain      = count_q;
        load        = 1'b0;
        word_ext    = '0;
        buf_d       = buf_q;
        count_d     = count_q;
        pos_d       = pos_q;
        err_d       = err_q;

        shift_legal = ShiftEn
                   && (NumShift <= SHF_W'(WIN_W))
                   && (CNT_W'(NumShift) <= count_q);
        shift_amt   = shift_legal ? CNT_W'(NumShift) : '0;
        remain      = count_q - shift_amt;
        load        = in_if.InValid && in_ready;
        word_ext    = {in_if.InWord, {PAD_W{1'b0}}} >> remain;

        if (Flush) begin
            buf_d   = '0;
            count_d = '0;
            pos_d   = '0;
            err_d   = 1'b0;
        end else begin
            buf_d   = (buf_q << shift_amt) | (load ? word_ext : '0);
            count_d = remain + (load ? CNT_W'(WORD_W) : '0);
            pos_d   = pos_q + POS_W'(shift_amt);
            err_d   = err_q | (ShiftEn && !shift_legal);
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            buf_q   <= '0;
            count_q <= '0;
            pos_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
        end
    end

    assign in_if.InReady    = in_ready;
    assign BitstreamShifted = buf_q[BUF_W-1 -: WIN_W];
    assign WindowValid      = (count_q >= CNT_W'(WIN_W));
    assign BitCount         = count_q;
    assign BitPos           = pos_q;
    assign Error            = err_q;

endmodule

// File: doc/cavlc_bit_window.md
Name: cavlc_bit_window

Overview:
- Upstream bitstream feeder for the CAVLC decode stages: coeff-token, level, and zero decode.
- Accepts 32-bit slice-data words over a valid/ready handshake and buffers them MSB-first.
- Presents a left-aligned 16-bit look-ahead window, `BitstreamShifted`, to the decoders.
- Consumes `NumShift`/`ShiftEn` from the active decoder, advancing up to 16 bits per cycle so every decoder can shift every cycle.

Parameters:
- WORD_W, 32, input word width; the first bitstream bit is `InWord[WORD_W-1]`.
- BUF_W, 64, internal bit buffer width; must be >= 2*WORD_W.
- WIN_W, 16, look-ahead window width; maximum legal shift per cycle.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- nReset  in  1  asynchronous active-low reset.
- Flush  in  1  synchronous clear of all buffered bits (new slice/NAL).
- InWord  in  WORD_W  next bitstream word, MSB first.
- InValid  in  1  `InWord` valid.
- InReady  out  1  buffer can accept a word this cycle.
- ShiftEn  in  1  consume `NumShift` bits this cycle.
- NumShift  in  5  bits to consume, 0..WIN_W.
- BitstreamShifted  out  WIN_W  next WIN_W unconsumed bits; `[WIN_W-1]` is the oldest.
- WindowValid  out  1  at least WIN_W bits buffered.
- BitCount  out  7  number of valid buffered bits, 0..BUF_W.
- BitPos  out  32  total bits consumed since reset/Flush; wraps modulo 2^32.
- Error  out  1  sticky protocol-violation flag.

Behaviour:
- State is held in registers:
  - Buf[BUF_W-1:0], left-aligned; valid bits occupy `Buf[BUF_W-1 -: Count]`.
  - Count.
  - BitPos.
  - Error.
- All state is cleared by `nReset` low immediately, independent of `Clk`.
- Outputs after reset: `BitstreamShifted`=0, `WindowValid`=0, `BitCount`=0, `BitPos`=0, `Error`=0, `InReady`=1.
- Combinational outputs, all derived from registers only:
  - `BitstreamShifted` = `Buf[BUF_W-1 -: WIN_W]`.
  - `WindowValid` = (Count >= WIN_W).
  - `InReady` = (Count <= BUF_W-WORD_W) && !Flush.
  - `BitCount` = Count.
- Bits below Count in Buf are always zero, so a partial window is zero-padded.
- A shift is legal when `ShiftEn` && `NumShift` <= WIN_W && `NumShift` <= Count. Let S = `NumShift` if legal, else 0.
- A load occurs when `InValid` && `InReady`.
- Per-cycle update when `Flush`=0:
  - Buf' = (Buf << S) | (load ? InWord << (BUF_W-WORD_W-(Count-S)) : 0).
  - Count' = Count - S + (load ? WORD_W : 0).
  - BitPos' = BitPos + S.
- Shift and load in the same cycle are fully supported.
- The new word lands immediately after the remaining bits, with no bubble.
- Latency:
  - A word accepted at edge N is visible in `BitstreamShifted` from edge N.
  - A shift at edge N shows the advanced window from edge N.
  - Back-to-back single-cycle shifts are therefore supported.
- `ShiftEn` with `NumShift`=0 is a legal no-op.
- Illegal shift (`NumShift` > WIN_W, or `NumShift` > Count):
  - Error <= 1.
  - Buf, Count and BitPos are unchanged by the shift.
  - A concurrent load still occurs.
- Error stays set until `Flush` or reset.
- Flush:
  - Buf, Count, BitPos and Error all <= 0.
  - Has priority over load and shift in the same cycle.
  - `InReady` is 0 during the `Flush` cycle, so no word is lost.
- Full condition: when Count > BUF_W-WORD_W, `InReady`=0. The upstream word is held, not dropped.
- Count never exceeds BUF_W; a load only occurs when Count <= BUF_W-WORD_W.
- Empty condition: Count=0 gives a window of 0 and `WindowValid`=0. Decoders must not shift while `WindowValid`=0, except when the final bits of a slice are shorter than WIN_W, which is legal provided `NumShift` <= Count.
- `InWord` is ignored when `InValid`=0.
- `ShiftEn` is ignored when X-free and 0.

Test Plan:
- Reset, load 0xA5A50F0F -> next cycle `BitstreamShifted`=0xA5A5, `WindowValid`=1, `BitCount`=32, `InReady`=1.
- From that state, shift 4 then shift 12 on consecutive cycles -> windows 0x5A50 then 0x0F0F; `BitCount`=16; `BitPos`=16.
- Count=16 (window 0x0F0F); same cycle load 0x12345678 and shift 8 -> `BitCount`=40, window 0x0F12; next shift 8 -> 0x1234.
- Load 0x11112222 and 0x33334444 (`BitCount`=64) -> `InReady`=0 with `InValid` held high and no accept; shift 16 -> `BitCount`=48, `InReady` still 0; shift 16 -> `BitCount`=32, `InReady`=1, and the held word is accepted on the next edge.
- Illegal shifts and Flush:
  - `BitCount`=8, shift 12 -> `Error`=1, `BitCount`=8, window unchanged.
  - `BitCount`=40, `NumShift`=20 -> `Error` stays 1, no shift.
  - Assert `Flush` with `InValid`=1 -> `BitCount`=0, `BitPos`=0, `Error`=0, word not accepted.
- `BitCount`=40, drop `nReset` mid-cycle -> outputs reset immediately without a `Clk` edge; after release, the first load behaves as in scenario 1.
